pcc_traffic_gen: RTL and testbench
==================================

# pcc_traffic_gen

Parametrised packet traffic generator for PCC NoC router test harnesses. Issues route-header, payload and tail flits on the PCC output port and paces payload with a token-bucket shaper. Handles fail/retry, suspend and cancel from the router and reports run statistics. Next-generation source node: runtime destination/source, selectable payload pattern, bounded retry with drop accounting, and suspend support.

## Interface
- DATAW, 66, flit width; must be ≥ max(66, 2+8*(HOPS+1))
- HOPS, 7, route bytes in header
- PKT_LEN, 128, payload flits per packet (1..65535)
- PKT_NUM, 3, packets per run (1..65535)
- GAP, 4, idle cycles between packets (≥1)
- TOKEN_T, 10, cycles per token refill (≥1)
- BUCKET_B, 5, bucket capacity (1..255)
- ACK_NUM, 1, pack_i pulses required to accept header (≥1)
- MAX_RETRY, 3, fail retries before packet is dropped
- BACKOFF, 2, stb-low cycles after a fail before header reissue (≥1)
- PAYLOAD_MODE, 0, 0 = 32-bit incrementing, 1 = 32-bit LFSR
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start_i  in  1  begin run; sampled in IDLE or DONE only
- route_i  in  8*HOPS  destination hops, latched at start
- src_i  in  8  source id, latched at start
- fail_i / pack_i / suspend_i / cancel_i  in  1 each  PCC router responses
- data_o  out  DATAW  flit
- stb_o  out  1  circuit request held
- fwd_o  out  1  data_o valid, one cycle per flit
- busy_o  out  1  state ≠ IDLE/DONE
- done_o  out  1  run complete (level)
- sent_cnt_o / drop_cnt_o  out  16 each  completed / dropped packets
- last_lat_o  out  32  cycles from header fwd_o to cancel_i of last completed packet

## Operation
- States: IDLE, ROUTE, BACKOFF, PAYLOAD, TAIL, GAP, DONE.
- Header: {2'b10, zero pad, route, src}. Payload: {2'b00, zero pad, pkt_idx[15:0], flit_idx[15:0], pattern[31:0]}. Tail: {2'b01, 1'b1, zeros}.
- IDLE/DONE + start_i: latch route/src; clear counters, pattern (inc → 0, LFSR → 32'h1) and token count; go ROUTE.
- ROUTE entry: stb_o=1; header with fwd_o pulse; retry count kept if arriving from BACKOFF, else cleared. Count pack_i; at ACK_NUM → PAYLOAD.
- fail_i in ROUTE: if retries < MAX_RETRY: retries+1, stb_o=0, BACKOFF for BACKOFF cycles, then ROUTE. Else drop_cnt+1, stb_o=0, → GAP.
- PAYLOAD: emit flit when tokens>0 && !suspend_i; consume one token; advance pattern (LFSR taps 32,22,2,1, shift-left). flit_idx 0..PKT_LEN-1. After flit PKT_LEN-1 → TAIL.
- TAIL: one tail flit (fwd_o pulse), then hold stb_o until cancel_i → stb_o=0, sent_cnt+1, latch latency, → GAP.
- cancel_i or fail_i in PAYLOAD, or cancel_i in ROUTE: abort, stb_o=0, drop_cnt+1, → GAP.
- GAP: GAP cycles, then ROUTE with pkt_idx+1, or DONE if sent+drop == PKT_NUM.
- Token bucket: every TOKEN_T cycles (free-running from reset) +1, saturate at BUCKET_B; refill + consume same cycle → unchanged. Bucket is full at start.

## Timing
- Reset: all outputs 0, state IDLE, tokens BUCKET_B.
- All outputs registered. start_i at edge n → stb_o, fwd_o, header at n+1.
- Flit decision cycle n → data_o/fwd_o at n+1. suspend_i blocks emission the same cycle, no skid.
- Priority: reset > cancel_i > fail_i > pack_i. pack_i ignored outside ROUTE; fail_i ignored in TAIL/GAP/BACKOFF; start_i ignored while busy_o.
- fwd_o never high while stb_o low. data_o holds last flit between pulses.
- Reset mid-packet: immediate return to reset state; no tail emitted.

## Test plan
- PKT_NUM=1, PKT_LEN=4, ACK_NUM=1, bucket full, one pack_i, cancel_i after tail → header, 4 payload (flit_idx 0..3, pattern 0..3), tail; sent_cnt=1, done_o=1.
- TOKEN_T=3, BUCKET_B=2, PKT_LEN=6 → first 2 flits back-to-back, then one flit every 3 cycles; total 6 flit pulses.
- fail_i on every header, MAX_RETRY=3, BACKOFF=2 → 4 headers, stb_o low 2 cycles between; drop_cnt=1, then GAP.
- suspend_i high 5 cycles mid-payload → no fwd_o during suspend, flit_idx continues with no gap or duplicate.
- PAYLOAD_MODE=1 → first patterns 32'h1, 32'h2, 32'h4, …; cancel_i mid-payload → drop_cnt+1, next packet pkt_idx=1.
- Reset asserted mid-PAYLOAD → next cycle all outputs 0, busy_o=0; a fresh start_i produces a normal header.

Source files
------------

// File: rtl/pcc_traffic_gen.sv
// Purpose : PCC NoC source node. Sends a route header, then token-paced payload
//           flits, then a tail flit. Handles fail/retry, suspend and cancel, and keeps run statistics.
// Latency : all outputs are registered. A decision made in cycle n appears on data_o/fwd_o in cycle n+1.
// Backpr. : suspend_i or an empty token bucket holds payload in place with no skid.
//           The circuit (stb_o) stays held until the router sends cancel_i or fail_i.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   start_i              begin a run (accepted only in IDLE or DONE)
//   route_i, src_i       destination hops and source id, latched at start
//   fail_i, pack_i,      router responses; priority is cancel > fail > pack
//   suspend_i, cancel_i
//   data_o, fwd_o        flit bus and its one-cycle valid strobe
//   stb_o                circuit request
//   busy_o, done_o       run in progress / run complete (level)
//   sent_cnt_o,          packets completed / dropped in this run
//   drop_cnt_o
//   last_lat_o           cycles from header fwd_o to cancel_i, for the last completed packet
module pcc_traffic_gen #(
    parameter int DATAW        = 66,
    parameter int HOPS         = 7,
    parameter int PKT_LEN      = 128,
    parameter int PKT_NUM      = 3,
    parameter int GAP          = 4,
    parameter int TOKEN_T      = 10,
    parameter int BUCKET_B     = 5,
    parameter int ACK_NUM      = 1,
    parameter int MAX_RETRY    = 3,
    parameter int BACKOFF      = 2,
    parameter int PAYLOAD_MODE = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_i,
    input  logic [8*HOPS-1:0]   route_i,
    input  logic [7:0]          src_i,
    input  logic                fail_i,
    input  logic                pack_i,
    input  logic                suspend_i,
    input  logic                cancel_i,
    output logic [DATAW-1:0]    data_o,
    output logic                stb_o,
    output logic                fwd_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [15:0]         sent_cnt_o,
    output logic [15:0]         drop_cnt_o,
    output logic [31:0]         last_lat_o
);

    localparam logic [15:0] PKT_LAST  = 16'(PKT_LEN - 1);
    localparam logic [15:0] PKT_TOTAL = 16'(PKT_NUM);
    localparam logic [15:0] GAP_LAST  = 16'(GAP - 1);
    localparam logic [15:0] BO_LAST   = 16'(BACKOFF - 1);
    localparam logic [15:0] ACK_LAST  = 16'(ACK_NUM - 1);
    localparam logic [15:0] RETRY_MAX = 16'(MAX_RETRY);
    localparam logic [31:0] TOK_LAST  = 32'(TOKEN_T - 1);
    localparam logic [7:0]  BKT_FULL  = 8'(BUCKET_B);
    localparam logic [31:0] PAT_INIT  = (PAYLOAD_MODE == 1) ? 32'h0000_0001 : 32'h0000_0000;
    // Galois form of x^32 + x^22 + x^2 + x + 1. A left-shifting Galois LFSR
    // seeded with 1 walks through 1, 2, 4, ... until bit 31 first falls out.
    localparam logic [31:0] LFSR_POLY = 32'h0040_0007;
    localparam logic [DATAW-1:0] TAIL_FLIT = {3'b011, {(DATAW-3){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROUTE,
        S_BACKOFF,
        S_PAYLOAD,
        S_TAIL,
        S_GAP,
        S_DONE
    } state_t;

    state_t              state;
    logic [8*HOPS-1:0]   route_q;
    logic [7:0]          src_q;
    logic [15:0]         pkt_idx;
    logic [15:0]         flit_idx;
    logic [31:0]         pattern;
    logic [15:0]         ack_cnt;
    logic [15:0]         retry_cnt;
    logic [15:0]         bo_cnt;
    logic [15:0]         gap_cnt;
    logic [31:0]         lat_cnt;
    logic                tail_sent;
    logic [31:0]         tick_cnt;
    logic [7:0]          tokens;
    logic                tick;
    logic                emit;
    logic                start_accept;

    function automatic logic [DATAW-1:0] hdr_flit(input logic [8*HOPS-1:0] r, input logic [7:0] s);
        logic [DATAW-1:0] f;
        f = '0;
        f[DATAW-1 -: 2] = 2'b10;
        f[8*HOPS+7:0]   = {r, s};
        return f;
    endfunction

    // The type bits (2'b00) and the pad stay zero from the '0 default.
    function automatic logic [DATAW-1:0] pay_flit(input logic [15:0] pk, input logic [15:0] fl,
                                                  input logic [31:0] pat);
        logic [DATAW-1:0] f;
        f = '0;
        f[63:0] = {pk, fl, pat};
        return f;
    endfunction

    function automatic logic [31:0] next_pattern(input logic [31:0] p);
        logic [31:0] n;
        if (PAYLOAD_MODE == 1) begin
            n = {p[30:0], 1'b0};
            if (p[31]) n = n ^ LFSR_POLY;
        end else begin
            n = p + 32'd1;
        end
        return n;
    endfunction

    assign tick         = (tick_cnt == TOK_LAST);
    assign start_accept = start_i && ((state == S_IDLE) || (state == S_DONE));
    // Cancel and fail take priority over a flit in the same cycle.
    // Suspend blocks the flit without any skid.
    assign emit         = (state == S_PAYLOAD) && !cancel_i && !fail_i && !suspend_i && (tokens != 8'd0);

    // The refill tick runs freely from reset, independent of run state.
    // A refill and a consume in the same cycle cancel out.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
            tokens   <= BKT_FULL;
        end else begin
            tick_cnt <= tick ? 32'd0 : tick_cnt + 32'd1;
            if (start_accept) begin
                tokens <= BKT_FULL;
            end else if (tick && !emit) begin
                if (tokens < BKT_FULL) tokens <= tokens + 8'd1;
            end else if (!tick && emit) begin
                tokens <= tokens - 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            route_q    <= '0;
            src_q      <= '0;
            pkt_idx    <= '0;
            flit_idx   <= '0;
            pattern    <= '0;
            ack_cnt    <= '0;
            retry_cnt  <= '0;
            bo_cnt     <= '0;
            gap_cnt    <= '0;
            lat_cnt    <= '0;
            tail_sent  <= 1'b0;
            data_o     <= '0;
            stb_o      <= 1'b0;
            fwd_o      <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            sent_cnt_o <= '0;
            drop_cnt_o <= '0;
            last_lat_o <= '0;
        end else begin
            fwd_o   <= 1'b0;
            // Free-running; it is zeroed each time a header goes out, so on
            // cancel it holds the cycle distance from that header.
            lat_cnt <= lat_cnt + 32'd1;

            case (state)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        route_q    <= route_i;
                        src_q      <= src_i;
                        sent_cnt_o <= '0;
                        drop_cnt_o <= '0;
                        last_lat_o <= '0;
                        pkt_idx    <= '0;
                        pattern    <= PAT_INIT;
                        retry_cnt  <= '0;
                        ack_cnt    <= '0;
                        done_o     <= 1'b0;
                        busy_o     <= 1'b1;
                        stb_o      <= 1'b1;
                        fwd_o      <= 1'b1;
                        data_o     <= hdr_flit(route_i, src_i);
                        lat_cnt    <= '0;
                        state      <= S_ROUTE;
                    end
                end

                S_ROUTE: begin
                    if (cancel_i) begin
                        stb_o      <= 1'b0;
                        drop_cnt_o <= drop_cnt_o + 16'd1;
                        gap_cnt    <= '0;
                        state      <= S_GAP;
                    end else if (fail_i) begin
                        stb_o <= 1'b0;
                        if (retry_cnt < RETRY_MAX) begin
                            retry_cnt <= retry_cnt + 16'd1;
                            bo_cnt    <= '0;
                            state     <= S_BACKOFF;
                        end else begin
                            drop_cnt_o <= drop_cnt_o + 16'd1;
                            gap_cnt    <= '0;
                            state      <= S_GAP;
                        end
                    end else if (pack_i) begin
                        if (ack_cnt == ACK_LAST) begin
                            ack_cnt  <= '0;
                            flit_idx <= '0;
                            state    <= S_PAYLOAD;
                        end else begin
                            ack_cnt <= ack_cnt + 16'd1;
                        end
                    end
                end

                // stb_o stays low for BACKOFF cycles. The reissued header keeps
                // retry_cnt so that the retry bound covers the whole packet.
                S_BACKOFF: begin
                    if (bo_cnt == BO_LAST) begin
                        ack_cnt <= '0;
                        stb_o   <= 1'b1;
                        fwd_o   <= 1'b1;
                        data_o  <= hdr_flit(route_q, src_q);
                        lat_cnt <= '0;
                        state   <= S_ROUTE;
                    end else begin
                        bo_cnt <= bo_cnt + 16'd1;
                    end
                end

                S_PAYLOAD: begin
                    if (cancel_i || fail_i) begin
                        stb_o      <= 1'b0;
                        drop_cnt_o <= drop_cnt_o + 16'd1;
                        gap_cnt    <= '0;
                        state      <= S_GAP;
                    end else if (emit) begin
                        data_o   <= pay_flit(pkt_idx, flit_idx, pattern);
                        fwd_o    <= 1'b1;
                        pattern  <= next_pattern(pattern);
                        flit_idx <= flit_idx + 16'd1;
                        if (flit_idx == PKT_LAST) begin
                            tail_sent <= 1'b0;
                            state     <= S_TAIL;
                        end
                    end
                end

                // The tail goes out unconditionally. A cancel that arrives
                // before it is sent counts as an abort, not a completion.
                S_TAIL: begin
                    if (!tail_sent) begin
                        if (cancel_i) begin
                            stb_o      <= 1'b0;
                            drop_cnt_o <= drop_cnt_o + 16'd1;
                            gap_cnt    <= '0;
                            state      <= S_GAP;
                        end else begin
                            data_o    <= TAIL_FLIT;
                            fwd_o     <= 1'b1;
                            tail_sent <= 1'b1;
                        end
                    end else if (cancel_i) begin
                        stb_o      <= 1'b0;
                        sent_cnt_o <= sent_cnt_o + 16'd1;
                        last_lat_o <= lat_cnt;
                        gap_cnt    <= '0;
                        state      <= S_GAP;
                    end
                end

                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        if ((sent_cnt_o + drop_cnt_o) == PKT_TOTAL) begin
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            pkt_idx   <= pkt_idx + 16'd1;
                            retry_cnt <= '0;
                            ack_cnt   <= '0;
                            stb_o     <= 1'b1;
                            fwd_o     <= 1'b1;
                            data_o    <= hdr_flit(route_q, src_q);
                            lat_cnt   <= '0;
                            state     <= S_ROUTE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pcc_traffic_gen.sv
// Purpose : directed bench for pcc_traffic_gen. Two instances share the same
//           stimulus and differ only in payload pattern mode (increment vs LFSR).
// Timing  : inputs change and outputs are sampled on the falling clock edge.
module tb_pcc_traffic_gen;

    localparam int DW = 66;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [55:0] route_i;
    logic [7:0]  src_i;
    logic        fail_i, pack_i, suspend_i, cancel_i;

    logic [DW-1:0] data_o, data1;
    logic          stb_o, fwd_o, busy_o, done_o;
    logic          stb1, fwd1, busy1, done1;
    logic [15:0]   sent_cnt_o, drop_cnt_o, sent1, drop1;
    logic [31:0]   last_lat_o, lat1;

    localparam logic [55:0] R0 = 56'h11_2233_4455_6677;
    localparam logic [7:0]  S0 = 8'hA5;
    localparam logic [55:0] R1 = 56'h01_0203_0405_0607;
    localparam logic [7:0]  S1 = 8'h3C;

    pcc_traffic_gen #(
        .DATAW(DW), .HOPS(7), .PKT_LEN(6), .PKT_NUM(3), .GAP(4), .TOKEN_T(3),
        .BUCKET_B(2), .ACK_NUM(1), .MAX_RETRY(3), .BACKOFF(2), .PAYLOAD_MODE(0)
    ) u_inc (
        .clk(clk), .reset(reset), .start_i(start_i), .route_i(route_i), .src_i(src_i),
        .fail_i(fail_i), .pack_i(pack_i), .suspend_i(suspend_i), .cancel_i(cancel_i),
        .data_o(data_o), .stb_o(stb_o), .fwd_o(fwd_o), .busy_o(busy_o), .done_o(done_o),
        .sent_cnt_o(sent_cnt_o), .drop_cnt_o(drop_cnt_o), .last_lat_o(last_lat_o)
    );

    pcc_traffic_gen #(
        .DATAW(DW), .HOPS(7), .PKT_LEN(6), .PKT_NUM(3), .GAP(4), .TOKEN_T(3),
        .BUCKET_B(2), .ACK_NUM(1), .MAX_RETRY(3), .BACKOFF(2), .PAYLOAD_MODE(1)
    ) u_lfsr (
        .clk(clk), .reset(reset), .start_i(start_i), .route_i(route_i), .src_i(src_i),
        .fail_i(fail_i), .pack_i(pack_i), .suspend_i(suspend_i), .cancel_i(cancel_i),
        .data_o(data1), .stb_o(stb1), .fwd_o(fwd1), .busy_o(busy1), .done_o(done1),
        .sent_cnt_o(sent1), .drop_cnt_o(drop1), .last_lat_o(lat1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] hdr_f(input logic [55:0] r, input logic [7:0] s);
        return {2'b10, r, s};
    endfunction

    function automatic logic [DW-1:0] pay_f(input logic [15:0] pk, input logic [15:0] fl, input logic [31:0] pat);
        return {2'b00, pk, fl, pat};
    endfunction

    localparam logic [DW-1:0] TAIL = {3'b011, 63'd0};

    // One falling edge. Any flit seen here must sit under a held circuit.
    task automatic step();
        @(negedge clk);
        if (fwd_o) chk("fwd_under_stb", 66'(stb_o), 66'd1);
    endtask

    task automatic wait_fwd(input int lim, input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim && !ok; i++) begin
            step();
            if (fwd_o) ok = 1'b1;
        end
        if (!ok) chk(tag, 66'(fwd_o), 66'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    int            fc [7];
    logic [DW-1:0] fd [7];
    logic [DW-1:0] fd1[7];
    logic [DW-1:0] last;
    bit            ok;
    int            h, tc, prev, c2;

    initial begin
        reset = 1'b1; start_i = 1'b0; route_i = R0; src_i = S0;
        fail_i = 1'b0; pack_i = 1'b0; suspend_i = 1'b0; cancel_i = 1'b0;
        repeat (3) step();

        chk("rst_stb",  66'(stb_o),  66'd0);
        chk("rst_fwd",  66'(fwd_o),  66'd0);
        chk("rst_data", data_o,      66'd0);
        chk("rst_busy", 66'(busy_o), 66'd0);
        chk("rst_done", 66'(done_o), 66'd0);
        chk("rst_sent", 66'(sent_cnt_o), 66'd0);
        chk("rst_drop", 66'(drop_cnt_o), 66'd0);
        chk("rst_lat",  66'(last_lat_o), 66'd0);
        reset = 1'b0;
        step(); step();

        // Packet 0: header, 6 paced payload flits, tail, then cancel completes it.
        start_i = 1'b1; step(); start_i = 1'b0;
        h = cyc;
        chk("hdr0",      data_o, hdr_f(R0, S0));
        chk("hdr0_fwd",  66'(fwd_o),  66'd1);
        chk("hdr0_stb",  66'(stb_o),  66'd1);
        chk("hdr0_busy", 66'(busy_o), 66'd1);
        route_i = 56'hFF_EEDD_CCBB_AA99;  // the header must keep using the latched route and source
        src_i   = 8'h00;
        pack_i = 1'b1; step(); pack_i = 1'b0;
        chk("hdr_one_pulse", 66'(fwd_o), 66'd0);
        for (int k = 0; k < 7; k++) begin
            wait_fwd(20, "pkt0_flit_timeout", ok);
            fc[k] = cyc; fd[k] = data_o; fd1[k] = data1;
        end
        chk("first_flit_lat", 66'(fc[0] - h), 66'd2);
        for (int k = 0; k < 6; k++) begin
            chk("pkt0_inc",  fd[k],  pay_f(16'd0, 16'(k), 32'(k)));
            chk("pkt0_lfsr", fd1[k], pay_f(16'd0, 16'(k), 32'd1 << k));
        end
        chk("pkt0_tail",     fd[6], TAIL);
        chk("tail_follows",  66'(fc[6] - fc[5]), 66'd1);
        chk("burst_b2b",     66'(fc[1] - fc[0]), 66'd1);
        chk("pace_4",        66'(fc[4] - fc[3]), 66'd3);
        chk("pace_5",        66'(fc[5] - fc[4]), 66'd3);
        step(); step();
        chk("stb_hold",  66'(stb_o), 66'd1);
        chk("tail_once", 66'(fwd_o), 66'd0);
        chk("data_hold", data_o, TAIL);
        cancel_i = 1'b1; tc = cyc; step(); cancel_i = 1'b0;
        chk("cancel_stb", 66'(stb_o), 66'd0);
        chk("sent_1",     66'(sent_cnt_o), 66'd1);
        chk("drop_0",     66'(drop_cnt_o), 66'd0);
        chk("last_lat",   66'(last_lat_o), 66'(tc - h));

        // A start pulse while busy is ignored.
        start_i = 1'b1; step(); start_i = 1'b0;
        chk("start_ignored", 66'(fwd_o), 66'd0);

        // Packet 1: every header fails. Expect 3 retries, then a drop.
        wait_fwd(20, "pkt1_hdr_timeout", ok);
        chk("gap_len", 66'(cyc - tc), 66'd5);
        prev = cyc;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                wait_fwd(20, "retry_hdr_timeout", ok);
                chk("retry_spacing", 66'(cyc - prev), 66'd3);
                prev = cyc;
            end
            chk("pkt1_hdr", data_o, hdr_f(R0, S0));
            fail_i = 1'b1; step(); fail_i = 1'b0;
            chk("fail_stb_low", 66'(stb_o), 66'd0);
        end
        chk("drop_1", 66'(drop_cnt_o), 66'd1);

        // Packet 2: suspend mid-payload, then cancel mid-payload.
        wait_fwd(20, "pkt2_hdr_timeout", ok);
        chk("gap_after_drop", 66'(cyc - prev), 66'd5);
        chk("pkt2_hdr", data_o, hdr_f(R0, S0));
        pack_i = 1'b1; step(); pack_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wait_fwd(20, "pkt2_flit_timeout", ok);
            chk("pkt2_idx", 66'(data_o[63:32]), 66'({16'd2, 16'(k)}));
        end
        last = data_o;
        suspend_i = 1'b1;
        for (int j = 0; j < 5; j++) begin
            step();
            chk("suspend_quiet", 66'(fwd_o), 66'd0);
        end
        suspend_i = 1'b0;
        chk("suspend_hold", data_o, last);
        for (int k = 2; k < 4; k++) begin
            wait_fwd(20, "pkt2_resume_timeout", ok);
            chk("pkt2_idx", 66'(data_o[63:32]), 66'({16'd2, 16'(k)}));
        end
        cancel_i = 1'b1; c2 = cyc; step(); cancel_i = 1'b0;
        chk("abort_stb", 66'(stb_o), 66'd0);
        chk("drop_2",    66'(drop_cnt_o), 66'd2);

        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            step();
            if (done_o) ok = 1'b1;
        end
        chk("done_seen",  66'(done_o), 66'd1);
        chk("done_lat",   66'(cyc - c2), 66'd5);
        chk("done_busy",  66'(busy_o), 66'd0);
        chk("done_stb",   66'(stb_o),  66'd0);
        chk("final_sent", 66'(sent_cnt_o), 66'd1);
        chk("final_drop", 66'(drop_cnt_o), 66'd2);

        // Second run from DONE, then a reset in the middle of the payload.
        route_i = R1; src_i = S1;
        start_i = 1'b1; step(); start_i = 1'b0;
        chk("run2_hdr",  data_o, hdr_f(R1, S1));
        chk("run2_sent", 66'(sent_cnt_o), 66'd0);
        chk("run2_drop", 66'(drop_cnt_o), 66'd0);
        chk("run2_done", 66'(done_o), 66'd0);
        pack_i = 1'b1; step(); pack_i = 1'b0;
        wait_fwd(20, "run2_flit_timeout", ok);
        chk("run2_flit0", data_o, pay_f(16'd0, 16'd0, 32'd0));
        reset = 1'b1; step();
        chk("mid_rst_stb",  66'(stb_o),  66'd0);
        chk("mid_rst_fwd",  66'(fwd_o),  66'd0);
        chk("mid_rst_data", data_o,      66'd0);
        chk("mid_rst_busy", 66'(busy_o), 66'd0);
        chk("mid_rst_sent", 66'(sent_cnt_o), 66'd0);
        chk("mid_rst_lat",  66'(last_lat_o), 66'd0);
        reset = 1'b0; step();
        start_i = 1'b1; step(); start_i = 1'b0;
        chk("post_rst_hdr",  data_o, hdr_f(R1, S1));
        chk("post_rst_fwd",  66'(fwd_o),  66'd1);
        chk("post_rst_busy", 66'(busy_o), 66'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
